// File: rtl/cassette_tx_sequencer_if.sv
// Byte-source / ULA-side signal bundle for cassette_tx_sequencer.
//   master : the byte source and command side (drives bit_tick, start, abort, byte stream)
//   slave  : the sequencer (drives byte_ready and all ULA-facing outputs)
// Signals:
//   bit_tick   one-clk pulse per cassette bit period
//   start      level, begin a save when idle
//   abort      level, cancel a save in progress
//   byte_data  next byte to send
//   byte_valid byte_data valid
//   byte_last  byte_data is the final byte of the block
//   byte_ready byte taken this clk when byte_valid & byte_ready
//   txd        serial bit to ULA TxD (mark = 1)
//   tx_enable  ULA tone enable
//   ctrl_out   ULA control word
//   ctrl_wr    one-clk strobe when ctrl_out changes
//   busy       save in progress
//   done       one-clk pulse on normal completion
//   underrun   sticky: source had no byte at a frame boundary
interface cassette_tx_sequencer_if;
  logic       bit_tick;
  logic       start;
  logic       abort;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       txd;
  logic       tx_enable;
  logic [7:0] ctrl_out;
  logic       ctrl_wr;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output bit_tick, start, abort, byte_data, byte_valid, byte_last,
    input  byte_ready, txd, tx_enable, ctrl_out, ctrl_wr, busy, done, underrun
  );

  modport slave (
    input  bit_tick, start, abort, byte_data, byte_valid, byte_last,
    output byte_ready, txd, tx_enable, ctrl_out, ctrl_wr, busy, done, underrun
  );
endinterface

// File: rtl/cassette_tx_sequencer.sv
// cassette_tx_sequencer
// Sequences one cassette save through the serial ULA: raises the motor bit in
// the ULA control word, waits a spin-up interval, sends a high-tone leader,
// frames each byte as start(0) + 8 data bits LSB first + stop(1), sends a
// trailer and drops the motor again. All ULA-facing outputs are registered;
// byte_ready is combinational so a byte is taken on the same clk it is offered.
// Ports:
//   clk    fast ULA clock
//   rst_n  asynchronous active-low reset
//   bus    cassette_tx_sequencer_if.slave (byte stream in, ULA controls out)
module cassette_tx_sequencer #(
  parameter int unsigned SPINUP_TICKS = 1200,
  parameter int unsigned LEADER_BITS  = 6000,
  parameter int unsigned TRAILER_BITS = 1200,
  parameter logic [2:0]  BAUD_SEL     = 3'b001,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cassette_tx_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPINUP_TICKS - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEADER_BITS - 1);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAILER_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPINUP,
    S_LEADER,
    S_DATA,
    S_TRAILER
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  // 0 = frame idle (between frames), 1..8 = next data bit to emit, 9 = stop bit next
  logic [3:0]       bit_cnt_q, bit_cnt_n;
  logic             last_q, last_n;
  logic             txd_q, txd_n;
  logic             txen_q, txen_n;
  logic             motor_q, motor_n;
  logic             ctrl_wr_q, ctrl_wr_n;
  logic             done_q, done_n;
  logic             underrun_q, underrun_n;
  logic [7:0]       shreg_q, shreg_n;
  logic             frame_idle;
  logic             boundary;

  assign frame_idle = (bit_cnt_q == 4'd0);
  // A frame boundary is offered only while a further byte is still expected.
  assign boundary   = (state_q == S_DATA) && frame_idle && bus.bit_tick &&
                      !bus.abort && !last_q;

  assign bus.byte_ready = boundary;
  assign bus.txd        = txd_q;
  assign bus.tx_enable  = txen_q;
  assign bus.ctrl_out   = {motor_q, 1'b0, BAUD_SEL, BAUD_SEL};
  assign bus.ctrl_wr    = ctrl_wr_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    bit_cnt_n  = bit_cnt_q;
    last_n     = last_q;
    txd_n      = txd_q;
    txen_n     = txen_q;
    motor_n    = motor_q;
    ctrl_wr_n  = 1'b0;
    done_n     = 1'b0;
    underrun_n = underrun_q;
    shreg_n    = shreg_q;

    if (state_q != S_IDLE && bus.abort) begin
      // Abort overrides every other event; the partial frame is dropped.
      state_n   = S_IDLE;
      cnt_n     = '0;
      bit_cnt_n = 4'd0;
      last_n    = 1'b0;
      txd_n     = 1'b1;
      txen_n    = 1'b0;
      motor_n   = 1'b0;
      ctrl_wr_n = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_n    = S_SPINUP;
            cnt_n      = '0;
            bit_cnt_n  = 4'd0;
            last_n     = 1'b0;
            txd_n      = 1'b1;
            txen_n     = 1'b0;
            motor_n    = 1'b1;
            ctrl_wr_n  = 1'b1;
            underrun_n = 1'b0;
          end
        end
        S_SPINUP: begin
          if (bus.bit_tick) begin
            if (cnt_q == SPIN_LAST) begin
              state_n = S_LEADER;
              cnt_n   = '0;
              txen_n  = 1'b1;
            end else begin
              cnt_n = cnt_q + CNT_ONE;
            end
          end
        end
        S_LEADER: begin
          if (bus.bit_tick) begin
            if (cnt_q == LEAD_LAST) begin
              state_n   = S_DATA;
              cnt_n     = '0;
              bit_cnt_n = 4'd0;
              last_n    = 1'b0;
            end else begin
              cnt_n = cnt_q + CNT_ONE;
            end
          end
        end
        S_DATA: begin
          if (bus.bit_tick) begin
            if (frame_idle) begin
              if (last_q) begin
                state_n = S_TRAILER;
                cnt_n   = '0;
              end else if (bus.byte_valid) begin
                shreg_n   = bus.byte_data;
                last_n    = bus.byte_last;
                txd_n     = 1'b0;
                bit_cnt_n = 4'd1;
              end else begin
                // No byte: line stays at mark, acting as an extra stop bit.
                underrun_n = 1'b1;
              end
            end else if (bit_cnt_q == 4'd9) begin
              txd_n     = 1'b1;
              bit_cnt_n = 4'd0;
            end else begin
              txd_n     = shreg_q[0];
              shreg_n   = {1'b0, shreg_q[7:1]};
              bit_cnt_n = bit_cnt_q + 4'd1;
            end
          end
        end
        S_TRAILER: begin
          if (bus.bit_tick) begin
            if (cnt_q == TRAIL_LAST) begin
              state_n   = S_IDLE;
              cnt_n     = '0;
              txen_n    = 1'b0;
              motor_n   = 1'b0;
              ctrl_wr_n = 1'b1;
              done_n    = 1'b1;
            end else begin
              cnt_n = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      last_q     <= 1'b0;
      txd_q      <= 1'b1;
      txen_q     <= 1'b0;
      motor_q    <= 1'b0;
      ctrl_wr_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      bit_cnt_q  <= bit_cnt_n;
      last_q     <= last_n;
      txd_q      <= txd_n;
      txen_q     <= txen_n;
      motor_q    <= motor_n;
      ctrl_wr_q  <= ctrl_wr_n;
      done_q     <= done_n;
      underrun_q <= underrun_n;
    end
  end

  // Shift register holds data only; bit_cnt gates every use of it.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_n;
  end

endmodule
